// File: rtl/ebpc_decoder_out_packer.sv
// Packs decoded DATA_W-bit words into WORDS_PER_BEAT-lane beats with per-lane strobes.
// Latency: the closing word (last lane or last_i) accepted at edge N is presented after edge N.
// Backpressure: rdy_o = ~vld_o | rdy_i, so a held output beat stalls the input; no bubbles while rdy_i=1.
//
// Ports
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   data_i/last_i/vld_i    decoded word stream from ebpc_decoder, rdy_o is its ready
//   data_o/strb_o/last_o   packed beat; lane k = data_o[k*DATA_W +: DATA_W], strb_o[k] marks it valid
//   vld_o/rdy_i            output handshake; beat is held stable while vld_o && !rdy_i
//   stat_clr_i, stat_words_o, stat_zeros_o
//                          only present when EBPC_PACKER_STATS_EN is defined: saturating counts of
//                          accepted words and of accepted zero words, synchronous clear
//
// Build option: define EBPC_PACKER_STATS_EN to add the statistics counters and their ports.

module ebpc_decoder_out_packer #(
    parameter int DATA_W         = 8,
    parameter int WORDS_PER_BEAT = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic                             last_i,
    input  logic                             vld_i,
    output logic                             rdy_o,
`ifdef EBPC_PACKER_STATS_EN
    input  logic                             stat_clr_i,
    output logic [31:0]                      stat_words_o,
    output logic [31:0]                      stat_zeros_o,
`endif
    output logic [DATA_W*WORDS_PER_BEAT-1:0] data_o,
    output logic [WORDS_PER_BEAT-1:0]        strb_o,
    output logic                             last_o,
    output logic                             vld_o,
    input  logic                             rdy_i
);

    localparam int BEAT_W = DATA_W * WORDS_PER_BEAT;
    localparam int CNT_W  = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORDS_PER_BEAT - 1);

    // One outgoing beat; held as a single register so data/strobe/last move together.
    typedef struct packed {
        logic [BEAT_W-1:0]         dat;
        logic [WORDS_PER_BEAT-1:0] strb;
        logic                      last;
    } beat_t;

    // Lanes at or above cnt_q are always zero in the accumulator because it is
    // cleared whenever a beat closes; that is what zero-pads partial beats.
    logic [WORDS_PER_BEAT-1:0][DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    beat_t                                 out_q, out_d;
    logic                                  vld_q, vld_d;

    logic                                  accept;
    logic                                  close;
    logic [WORDS_PER_BEAT-1:0][DATA_W-1:0] beat_lanes;
    logic [WORDS_PER_BEAT-1:0]             beat_strb;

    // Ready never looks at vld_i/data_i/last_i, only at the output register and rdy_i.
    assign rdy_o  = ~vld_q | rdy_i;
    assign accept = vld_i & rdy_o;
    assign close  = accept & ((cnt_q == LAST_LANE) | last_i);

    always_comb begin
        // Closing beat = accumulator with the incoming word dropped into lane cnt_q.
        beat_lanes        = acc_q;
        beat_lanes[cnt_q] = data_i;
        beat_strb         = '0;
        for (int k = 0; k < WORDS_PER_BEAT; k++) begin
            beat_strb[k] = (CNT_W'(k) <= cnt_q);
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_d = out_q;
        vld_d = vld_q;

        if (accept) begin
            if (close) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d[cnt_q] = data_i;
                cnt_d        = cnt_q + CNT_W'(1);
            end
        end

        // close implies rdy_o, i.e. the output is empty or draining this cycle,
        // so loading here never overwrites a beat that has not been taken.
        if (close) begin
            out_d.dat  = beat_lanes;
            out_d.strb = beat_strb;
            out_d.last = last_i;
            vld_d      = 1'b1;
        end else if (rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign data_o = out_q.dat;
    assign strb_o = out_q.strb;
    assign last_o = out_q.last;
    assign vld_o  = vld_q;

`ifdef EBPC_PACKER_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_zeros_q, stat_zeros_d;

    always_comb begin
        stat_words_d = stat_words_q;
        stat_zeros_d = stat_zeros_q;
        // Clear takes priority over an increment in the same cycle.
        if (stat_clr_i) begin
            stat_words_d = '0;
            stat_zeros_d = '0;
        end else if (accept) begin
            if (stat_words_q != '1) begin
                stat_words_d = stat_words_q + 32'd1;
            end
            if ((data_i == '0) && (stat_zeros_q != '1)) begin
                stat_zeros_d = stat_zeros_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_words_q <= '0;
            stat_zeros_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_zeros_q <= stat_zeros_d;
        end
    end

    assign stat_words_o = stat_words_q;
    assign stat_zeros_o = stat_zeros_q;
`endif

endmodule

// File: tb/tb_ebpc_decoder_out_packer.sv
// Directed and randomized checks of ebpc_decoder_out_packer against a queue-based beat model.
// Latency: outputs are sampled 1 time unit after each falling edge, inputs change on falling edges.
// Backpressure: rdy_i is driven per step; random output stalls are exercised in the random phase.

module tb_ebpc_decoder_out_packer;

    localparam int DW  = 8;
    localparam int WPB = 4;
    localparam int NRW = 200;

    logic              clk_i;
    logic              rst_i;
    logic [DW-1:0]     data_i;
    logic              last_i;
    logic              vld_i;
    logic              rdy_o;
    logic [DW*WPB-1:0] data_o;
    logic [WPB-1:0]    strb_o;
    logic              last_o;
    logic              vld_o;
    logic              rdy_i;
`ifdef EBPC_PACKER_STATS_EN
    logic              stat_clr_i;
    logic [31:0]       stat_words_o;
    logic [31:0]       stat_zeros_o;
`endif

    ebpc_decoder_out_packer #(.DATA_W(DW), .WORDS_PER_BEAT(WPB)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .last_i       (last_i),
        .vld_i        (vld_i),
        .rdy_o        (rdy_o),
`ifdef EBPC_PACKER_STATS_EN
        .stat_clr_i   (stat_clr_i),
        .stat_words_o (stat_words_o),
        .stat_zeros_o (stat_zeros_o),
`endif
        .data_o       (data_o),
        .strb_o       (strb_o),
        .last_o       (last_o),
        .vld_o        (vld_o),
        .rdy_i        (rdy_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW*WPB-1:0] data;
        logic [WPB-1:0]    strb;
        logic              last;
    } beat_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words accepted since the last beat, and beats expected at the output.
    logic [DW-1:0] cur_q[$];
    beat_t         exp_q[$];

    // Outputs as sampled at the start of the most recent step.
    logic              s_vld, s_rdy, s_last;
    logic [DW*WPB-1:0] s_data;
    logic [WPB-1:0]    s_strb;
`ifdef EBPC_PACKER_STATS_EN
    logic [31:0]       s_words, s_zeros;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A beat is the accepted words in order, lane i = i-th word, closed at 4 words or on last.
    task automatic model_push(input logic [DW-1:0] d, input logic l);
        beat_t b;
        cur_q.push_back(d);
        if (l || cur_q.size() == WPB) begin
            b.data = '0;
            for (int i = 0; i < cur_q.size(); i++) begin
                b.data = b.data | ((DW*WPB)'(cur_q[i]) << (DW * i));
            end
            b.strb = WPB'((1 << cur_q.size()) - 1);
            b.last = l;
            exp_q.push_back(b);
            cur_q.delete();
        end
    endtask

    // One clock cycle: drive inputs, sample outputs, score any output and input transfer.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                        output logic acc);
        beat_t e;
        @(negedge clk_i);
        vld_i  = v;
        data_i = d;
        last_i = l;
        rdy_i  = r;
        #1;
        s_vld  = vld_o;
        s_rdy  = rdy_o;
        s_data = data_o;
        s_strb = strb_o;
        s_last = last_o;
`ifdef EBPC_PACKER_STATS_EN
        s_words = stat_words_o;
        s_zeros = stat_zeros_o;
`endif
        if (vld_o && rdy_i) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 64'(data_o), 64'(e.data));
                chk("beat_strb", 64'(strb_o), 64'(e.strb));
                chk("beat_last", 64'(last_o), 64'(e.last));
            end
        end
        acc = vld_i && rdy_o;
        if (acc) model_push(d, l);
        @(posedge clk_i);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, acc);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle_vld"}, 64'(vld_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [DW-1:0] rw[NRW];
        logic          rl[NRW];
        int            idx, in_gap, out_gap, cyc;
        logic          v, r;

        rst_i  = 1'b1;
        vld_i  = 1'b0;
        data_i = '0;
        last_i = 1'b0;
        rdy_i  = 1'b0;
`ifdef EBPC_PACKER_STATS_EN
        stat_clr_i = 1'b0;
`endif
        #12;
        chk("rst_vld",  64'(vld_o),  64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_strb", 64'(strb_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_rdy",  64'(rdy_o),  64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Two full beats, last on the 8th word, no input stalls.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'(i + 1), i == 7, 1'b1, acc);
            chk("t1_no_stall", 64'(acc), 64'd1);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t1_second_beat", 64'(s_data), 64'h0807_0605);
        drain("t1");

        // Full beat then a two-lane partial beat closed by last.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'(8'h11 + i), i == 5, 1'b1, acc);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t2_partial_data", 64'(s_data), 64'h0000_1615);
        chk("t2_partial_strb", 64'(s_strb), 64'b0011);
        drain("t2");

        // Single word with last: one-lane beat visible one cycle after acceptance.
        step(1'b1, 8'hAB, 1'b1, 1'b1, acc);
        chk("t3_accept", 64'(acc), 64'd1);
        chk("t3_vld_before", 64'(s_vld), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t3_vld_after", 64'(s_vld), 64'd1);
        chk("t3_data", 64'(s_data), 64'h0000_00AB);
        chk("t3_strb", 64'(s_strb), 64'b0001);
        chk("t3_last", 64'(s_last), 64'd1);
        drain("t3");

        // Output stall for 5 cycles with a word waiting at the input.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'(8'h21 + i), 1'b0, 1'b0, acc);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h25, 1'b0, 1'b0, acc);
            chk("t4_stall_rdy", 64'(s_rdy), 64'd0);
            chk("t4_stall_acc", 64'(acc), 64'd0);
            chk("t4_stall_vld", 64'(s_vld), 64'd1);
            chk("t4_stall_data", 64'(s_data), 64'h2423_2221);
            chk("t4_stall_strb", 64'(s_strb), 64'b1111);
        end
        step(1'b1, 8'h25, 1'b0, 1'b1, acc);
        chk("t4_release_acc", 64'(acc), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, DW'(8'h26 + i), i == 2, 1'b1, acc);
        end
        drain("t4");

        // Random word stream with random gaps on the input and random output stalls.
        for (int i = 0; i < NRW; i++) begin
            rw[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom_range(1, 255));
            rl[i] = ($urandom_range(0, 6) == 0) || (i == NRW - 1);
        end
        idx = 0;
        in_gap = 0;
        out_gap = 0;
        cyc = 0;
        while (idx < NRW && cyc < 4000) begin
            v = (in_gap == 0);
            r = (out_gap == 0);
            if (out_gap > 0) out_gap--;
            else if ($urandom_range(0, 2) == 0) out_gap = $urandom_range(1, 3);
            step(v, v ? rw[idx] : '0, v ? rl[idx] : 1'b0, r, acc);
            if (acc) begin
                idx++;
                in_gap = $urandom_range(0, 3);
            end else if (in_gap > 0) begin
                in_gap--;
            end
            cyc++;
        end
        chk("t5_all_words_accepted", 64'(idx), 64'(NRW));
        drain("t5");

        // Asynchronous reset with two words in the accumulator.
        step(1'b1, 8'h31, 1'b0, 1'b1, acc);
        step(1'b1, 8'h32, 1'b0, 1'b1, acc);
        @(negedge clk_i);
        vld_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_vld",  64'(vld_o),  64'd0);
        chk("t6_rst_data", 64'(data_o), 64'd0);
        chk("t6_rst_strb", 64'(strb_o), 64'd0);
        chk("t6_rst_last", 64'(last_o), 64'd0);
        cur_q.delete();
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'(8'h41 + i), 1'b0, 1'b1, acc);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t6_clean_data", 64'(s_data), 64'h4443_4241);
        chk("t6_clean_strb", 64'(s_strb), 64'b1111);
        drain("t6");

`ifdef EBPC_PACKER_STATS_EN
        // Clear coincident with an accepted word: clear wins.
        stat_clr_i = 1'b1;
        step(1'b1, 8'h55, 1'b1, 1'b1, acc);
        stat_clr_i = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t7_clr_words", 64'(s_words), 64'd0);
        chk("t7_clr_zeros", 64'(s_zeros), 64'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0 || i == 2 || i == 5) ? 8'h00 : DW'(i), i == 9, 1'b1, acc);
        end
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t7_words", 64'(s_words), 64'd10);
        chk("t7_zeros", 64'(s_zeros), 64'd3);
        stat_clr_i = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1, acc);
        stat_clr_i = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t7_words_cleared", 64'(s_words), 64'd0);
        chk("t7_zeros_cleared", 64'(s_zeros), 64'd0);
        drain("t7");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
